// File: rtl/pwm_servo_array.sv
// Multi-channel servo PWM generator with a shared frame counter, a single command port and
// per-channel slew-limited high times that only change at the frame wrap.
module pwm_servo_array #(
  parameter int N_CH      = 2,
  parameter int CNT_W     = 21,
  parameter int PERIOD    = 2000000,
  parameter int PULSE_MIN = 100000,
  parameter int PULSE_MAX = 200000,
  parameter int MAX_STEP  = 10000,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [CH_W-1:0]  cmd_ch,
  input  logic [CNT_W-1:0] cmd_width,
  output logic             cmd_ready,
  output logic [N_CH-1:0]  pwm,
  output logic             frame_start,
  output logic [CNT_W-1:0] count_out
);

  localparam logic [0:0]       IDLE  = 1'b0;
  localparam logic [0:0]       RUN   = 1'b1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] MIN_W = CNT_W'(PULSE_MIN);
  localparam logic [CNT_W-1:0] MAX_W = CNT_W'(PULSE_MAX);
  localparam logic [CNT_W:0]   STEP  = (CNT_W + 1)'(MAX_STEP);

  logic [CNT_W-1:0] count;
  logic             armed;
  logic             ready_q;
  logic             wrap;
  logic             accept;
  logic [CNT_W-1:0] clamped;
  logic [N_CH-1:0]  pwm_next;
  logic [N_CH-1:0]  pwm_q;

  // armed holds the counter at 0 for the reset-state cycle; ready_q lags it by one more cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= '0;
      armed   <= 1'b0;
      ready_q <= 1'b0;
      pwm_q   <= '0;
    end else begin
      armed   <= 1'b1;
      ready_q <= armed;
      pwm_q   <= pwm_next;
      if (armed) count <= wrap ? '0 : count + CNT_W'(1);
    end
  end

  assign wrap        = armed && (count == LAST);
  assign accept      = cmd_valid && cmd_ready;
  assign cmd_ready   = reset && ready_q;
  assign frame_start = armed && (count == '0);
  assign count_out   = count;
  assign pwm         = pwm_q;

  always_comb begin
    clamped = cmd_width;
    if (cmd_width == '0)        clamped = '0;
    else if (cmd_width < MIN_W) clamped = MIN_W;
    else if (cmd_width > MAX_W) clamped = MAX_W;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] slewed;
    logic [0:0]       state;
    logic [CNT_W:0]   t_ext;
    logic [CNT_W:0]   a_ext;

    assign t_ext = {1'b0, target};
    assign a_ext = {1'b0, active};

    // One extra bit keeps active +/- STEP from wrapping before the comparison
    always_comb begin
      slewed = target;
      if (MAX_STEP != 0) begin
        if (t_ext > a_ext + STEP)      slewed = CNT_W'(a_ext + STEP);
        else if (a_ext > t_ext + STEP) slewed = CNT_W'(a_ext - STEP);
      end
    end

    // The wrap update reads target before this cycle's command write lands
    always_ff @(posedge clk) begin
      if (!reset) begin
        target <= '0;
        active <= '0;
        state  <= IDLE;
      end else begin
        if (wrap) begin
          if (target == '0) begin
            state  <= IDLE;
            active <= '0;
          end else if (state == IDLE) begin
            state  <= RUN;
            active <= target;
          end else begin
            active <= slewed;
          end
        end
        if (accept && (cmd_ch == CH_W'(i))) target <= clamped;
      end
    end

    assign pwm_next[i] = (state == RUN) && (count < active);
  end

endmodule

// File: tb/tb_pwm_servo_array.sv
// Self-checking bench for pwm_servo_array: per-cycle reference model under random stimulus,
// plus table-driven frame-level high-time vectors and directed corner sequences.
module tb_pwm_servo_array;

  localparam int N_CH  = 2;
  localparam int CNT_W = 8;
  localparam int PER   = 20;
  localparam int PMIN  = 4;
  localparam int PMAX  = 10;
  localparam int STEP  = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [0:0]       cmd_ch = '0;
  logic [CNT_W-1:0] cmd_width = '0;
  logic             cmd_ready;
  logic [N_CH-1:0]  pwm;
  logic             frame_start;
  logic [CNT_W-1:0] count_out;

  int checks = 0;
  int errors = 0;

  pwm_servo_array #(
    .N_CH(N_CH), .CNT_W(CNT_W), .PERIOD(PER),
    .PULSE_MIN(PMIN), .PULSE_MAX(PMAX), .MAX_STEP(STEP)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch),
    .cmd_width(cmd_width), .cmd_ready(cmd_ready), .pwm(pwm),
    .frame_start(frame_start), .count_out(count_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int              ch;
    int              pre;
    int              w;
    logic [3:0][7:0] hi;
  } vec_t;

  function automatic vec_t mk(int ch, int pre, int w, int e0, int e1, int e2, int e3);
    vec_t v;
    v.ch = ch; v.pre = pre; v.w = w;
    v.hi[0] = 8'(e0); v.hi[1] = 8'(e1); v.hi[2] = 8'(e2); v.hi[3] = 8'(e3);
    return v;
  endfunction

  function automatic int clamp_w(int w);
    if (w == 0) return 0;
    if (w < PMIN) return PMIN;
    if (w > PMAX) return PMAX;
    return w;
  endfunction

  function automatic int toward(int a, int t);
    if (t > a) return (t - a > STEP) ? a + STEP : t;
    return (a - t > STEP) ? a - STEP : t;
  endfunction

  // Reference model: frame counter, per-channel target/active/running, registered pwm
  int m_count, m_armed, m_ready;
  int m_tgt[N_CH], m_act[N_CH], m_run[N_CH], m_pwm[N_CH];
  bit mdl_en = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_count = 0; m_armed = 0; m_ready = 0;
      for (int i = 0; i < N_CH; i++) begin
        m_tgt[i] = 0; m_act[i] = 0; m_run[i] = 0; m_pwm[i] = 0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) m_pwm[i] = (m_run[i] != 0 && m_count < m_act[i]) ? 1 : 0;
      if (m_armed != 0 && m_count == PER - 1) begin
        for (int i = 0; i < N_CH; i++) begin
          if (m_tgt[i] == 0) begin
            m_run[i] = 0; m_act[i] = 0;
          end else if (m_run[i] == 0) begin
            m_run[i] = 1; m_act[i] = m_tgt[i];
          end else begin
            m_act[i] = toward(m_act[i], m_tgt[i]);
          end
        end
      end
      if (m_ready != 0 && cmd_valid && int'(cmd_ch) < N_CH) m_tgt[cmd_ch] = clamp_w(int'(cmd_width));
      if (m_armed != 0) m_count = (m_count == PER - 1) ? 0 : m_count + 1;
      m_ready = m_armed;
      m_armed = 1;
    end
  end

  always @(negedge clk) begin
    if (mdl_en) begin
      int  e_fs, e_rdy;
      logic [N_CH-1:0] e_pwm;
      e_fs  = (m_armed != 0 && m_count == 0) ? 1 : 0;
      e_rdy = (reset && m_ready != 0) ? 1 : 0;
      for (int i = 0; i < N_CH; i++) e_pwm[i] = m_pwm[i][0];
      checks++;
      if (int'(count_out) != m_count || int'(frame_start) != e_fs ||
          int'(cmd_ready) != e_rdy || pwm !== e_pwm) begin
        errors++;
        $display("[TB] FAIL model_cycle t=%0t: got count=%0d fs=%0b rdy=%0b pwm=%b, expected count=%0d fs=%0d rdy=%0d pwm=%b",
                 $time, count_out, frame_start, cmd_ready, pwm, m_count, e_fs, e_rdy, e_pwm);
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit valid, input int ch, input int w);
    cmd_valid = valid;
    cmd_ch    = 1'(ch);
    cmd_width = CNT_W'(w);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cmd_valid = 1'b0;
    step();
    step();
    checkOutput("rst_count", int'(count_out), 0);
    checkOutput("rst_frame_start", int'(frame_start), 0);
    checkOutput("rst_cmd_ready", int'(cmd_ready), 0);
    checkOutput("rst_pwm", int'(pwm), 0);
    reset = 1'b1;
    step();
    checkOutput("first_frame_start", int'(frame_start), 1);
    checkOutput("first_count", int'(count_out), 0);
    checkOutput("first_cmd_ready", int'(cmd_ready), 0);
  endtask

  task automatic advance_to(input int c);
    for (int k = 0; k < 4 * PER; k++) begin
      if (int'(count_out) == c) return;
      step();
    end
    checkOutput("advance_timeout", int'(count_out), c);
  endtask

  // Accumulates pwm highs from the current cycle until the next frame_start
  task automatic run_to_frame(output int h0, output int h1, output int cyc);
    h0 = 0; h1 = 0; cyc = 0;
    for (int k = 0; k < 4 * PER; k++) begin
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
      step();
      cyc++;
      if (frame_start === 1'b1) return;
    end
    checkOutput("frame_timeout", cyc, PER);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int h0, h1, cyc, hc, ho;
    do_reset();
    advance_to(5);
    if (v.pre != 0) begin
      applyStimulus(1'b1, v.ch, v.pre);
      run_to_frame(h0, h1, cyc);
      advance_to(5);
    end
    applyStimulus(1'b1, v.ch, v.w);
    run_to_frame(h0, h1, cyc);
    if (v.pre == 0) checkOutput($sformatf("vec%0d_write_frame", idx), (v.ch == 0) ? h0 : h1, 0);
    for (int f = 0; f < 4; f++) begin
      run_to_frame(h0, h1, cyc);
      hc = (v.ch == 0) ? h0 : h1;
      ho = (v.ch == 0) ? h1 : h0;
      checkOutput($sformatf("vec%0d_high_f%0d", idx, f), hc, int'(v.hi[f]));
      checkOutput($sformatf("vec%0d_other_f%0d", idx, f), ho, 0);
    end
  endtask

  vec_t vecs[7];

  initial begin
    int h0, h1, cyc;
    vecs[0] = mk(0, 0, 6,   6, 6, 6, 6);
    vecs[1] = mk(0, 4, 10,  6, 8, 10, 10);
    vecs[2] = mk(1, 0, 2,   4, 4, 4, 4);
    vecs[3] = mk(1, 4, 50,  6, 8, 10, 10);
    vecs[4] = mk(1, 10, 0,  0, 0, 0, 0);
    vecs[5] = mk(0, 10, 5,  8, 6, 5, 5);
    vecs[6] = mk(1, 0, 200, 10, 10, 10, 10);

    step();
    mdl_en = 1'b1;

    // Idle frames after reset: no output, frame_start every PER cycles
    do_reset();
    for (int f = 0; f < 3; f++) begin
      run_to_frame(h0, h1, cyc);
      checkOutput($sformatf("idle_f%0d_pwm", f), h0 + h1, 0);
      checkOutput($sformatf("idle_f%0d_len", f), cyc, PER);
    end
    checkOutput("idle_ready", int'(cmd_ready), 1);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Stop written in the wrap cycle: the next frame still runs
    do_reset();
    advance_to(5);
    applyStimulus(1'b1, 0, 10);
    run_to_frame(h0, h1, cyc);
    advance_to(PER - 1);
    applyStimulus(1'b1, 0, 0);
    checkOutput("wrapstop_fs", int'(frame_start), 1);
    run_to_frame(h0, h1, cyc);
    checkOutput("wrapstop_still_runs", h0, 10);
    run_to_frame(h0, h1, cyc);
    checkOutput("wrapstop_idle", h0, 0);

    // Reset in the middle of a pulse, with a command held during reset
    do_reset();
    advance_to(5);
    applyStimulus(1'b1, 0, 8);
    run_to_frame(h0, h1, cyc);
    advance_to(4);
    checkOutput("midrst_pulse_high", int'(pwm[0]), 1);
    reset = 1'b0;
    cmd_valid = 1'b1;
    cmd_ch = 1'(3);
    cmd_width = CNT_W'(6);
    step();
    checkOutput("midrst_pwm", int'(pwm), 0);
    checkOutput("midrst_ready", int'(cmd_ready), 0);
    step();
    reset = 1'b1;
    cmd_valid = 1'b0;
    step();
    checkOutput("midrst_release_fs", int'(frame_start), 1);
    for (int f = 0; f < 2; f++) begin
      run_to_frame(h0, h1, cyc);
      checkOutput($sformatf("midrst_f%0d_pwm", f), h0 + h1, 0);
    end

    // Random commands and occasional resets against the model
    for (int k = 0; k < 4000; k++) begin
      int wsel;
      reset = ($urandom_range(0, 399) != 0);
      wsel = int'($urandom_range(0, 9));
      applyStimulus($urandom_range(0, 5) == 0, int'($urandom_range(0, 1)),
                    (wsel == 0) ? 0 : (wsel == 1) ? PMIN - 1 : (wsel == 2) ? PMAX + 1 :
                    int'($urandom_range(0, 255)));
    end
    reset = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_servo_array.md
PWM_SERVO_ARRAY -- requirements
Module: pwm_servo_array

Interface
REQ-001 Parameter N_CH, default 2: number of independent PWM channels, range 1..8.
REQ-002 Parameter CNT_W, default 21: width of period counter and pulse-width values.
REQ-003 Parameter PERIOD, default 2000000: counter cycles per PWM frame, i.e. 20 ms at 100 MHz; must be >PULSE_MAX.
REQ-004 Parameter PULSE_MIN, default 100000: minimum non-zero high time in cycles.
REQ-005 Parameter PULSE_MAX, default 200000: maximum high time in cycles.
REQ-006 Parameter MAX_STEP, default 10000: maximum change of a running channel's high time per frame; 0 disables slew limiting.
REQ-007 clk  input  1  system clock; the block uses only this clock.
REQ-008 reset  input  1  synchronous, active-low reset.
REQ-009 cmd_valid  input  1  command strobe.
REQ-010 cmd_ch  input  max(1,$clog2(N_CH))  target channel index.
REQ-011 cmd_width  input  CNT_W  requested high time in cycles; 0 means stop.
REQ-012 cmd_ready  output  1  command accept indication.
REQ-013 pwm  output  N_CH  PWM outputs, one bit per channel.
REQ-014 frame_start  output  1  one-cycle pulse marking frame count 0.
REQ-015 count_out  output  CNT_W  current frame counter value.

Function
REQ-016 The frame counter SHALL count 0..PERIOD-1, then wrap to 0.
REQ-017 frame_start SHALL be 1 exactly in cycles where the counter equals 0.
REQ-018 cmd_ready SHALL be 1 in every cycle except the reset cycle and the cycle after reset.
REQ-019 A command SHALL be accepted when cmd_valid and cmd_ready are both 1.
REQ-020 A command with cmd_ch >= N_CH SHALL be accepted and discarded with no state change.
REQ-021 An accepted non-zero cmd_width SHALL be clamped to [PULSE_MIN, PULSE_MAX] and written to that channel's target register.
REQ-022 An accepted cmd_width of 0 SHALL write target 0, which is a stop request.
REQ-023 A later command to the same channel within a frame SHALL overwrite the target register; the last one wins.
REQ-024 Each channel SHALL have states IDLE and RUN plus an active-width register.
REQ-025 Active width and state SHALL update only on the wrap cycle, i.e. the cycle where counter = PERIOD-1, using the target value held before that cycle's command write.
REQ-026 A command accepted in the wrap cycle SHALL take effect at the following wrap.
REQ-027 Wrap transition IDLE -> RUN SHALL occur when target != 0; active is then set to target directly, with no slew.
REQ-028 Wrap transition RUN -> IDLE SHALL occur when target == 0; active is then set to 0.
REQ-029 In RUN with target != 0 and MAX_STEP > 0, active SHALL move toward target by min(|target-active|, MAX_STEP) per wrap.
REQ-030 With MAX_STEP = 0, active SHALL equal target at the wrap.
REQ-031 pwm[i] SHALL be 1 iff channel i is in RUN and counter < active[i]; IDLE SHALL force 0.
REQ-032 pwm SHALL be registered, so pwm[i] reflects the counter value of the previous cycle; there are no glitches.
REQ-033 Slew arithmetic SHALL be unsigned CNT_W+1 bits with no overflow; active SHALL never leave [PULSE_MIN, PULSE_MAX] while in RUN.
REQ-034 Simultaneous commands are impossible because there is one port; channels are otherwise fully independent.

Reset
REQ-035 While reset=0 at a clk edge: counter=0, all channels IDLE, target=0, active=0.
REQ-036 While reset=0 at a clk edge: pwm=0, frame_start=0, cmd_ready=0, count_out=0.
REQ-037 Reset asserted mid-frame SHALL discard all pending targets and abort any slew.
REQ-038 After reset=1, the first counted cycle SHALL have counter=0 and frame_start=1.
REQ-039 Commands presented during reset SHALL be ignored.

Verification
Bench parameters for all scenarios: N_CH=2, CNT_W=8, PERIOD=20, PULSE_MIN=4, PULSE_MAX=10, MAX_STEP=2.
REQ-040 Release reset, send no command for 3 frames -> pwm=00 throughout; frame_start pulses every 20 cycles.
REQ-041 Mid-frame, write ch0 width 6 -> pwm[0] stays 0 until the next wrap, then is high for exactly 6 cycles per frame.
REQ-042 ch0 running at 4, write 10 -> high times per frame are 6, 8, 10, 10.
REQ-043 Write ch1 width 2, then width 50 -> clamped high times of 4 and then 10; width 50 while running at 4 yields 6, 8, 10.
REQ-044 Write ch0 width 0 in the wrap cycle -> the next frame still runs; the channel is IDLE in the frame after.
REQ-045 Assert reset mid-pulse with ch0 at 8, write cmd_ch=3 -> pwm=0 at once; no channel starts after release; the cmd_ch=3 command is ignored.
